// File: rtl/ray_column_sched_if.sv
// Signal bundle between the column scheduler, the frame requester, the ray caster
// and the column-buffer write port. The slave modport is the scheduler's view.
interface ray_column_sched_if #(
    parameter int HEIGHT_W = 8
);
    logic                frame_start;
    logic [6:0]          frame_turn;
    logic [15:0]         frame_pos_x;
    logic [15:0]         frame_pos_y;
    logic                frame_busy;
    logic                frame_done;
    logic                timeout_err;

    logic [8:0]          ray_x;
    logic [6:0]          ray_turn;
    logic [15:0]         ray_map_pos_x;
    logic [15:0]         ray_map_pos_y;
    logic                ray_start;
    logic                ray_busy;
    logic [23:0]         ray_line_height;
    logic [7:0]          ray_line_color;
    logic [6:0]          ray_line_tex_x;

    logic                col_we;
    logic [8:0]          col_addr;
    logic [HEIGHT_W-1:0] col_height;
    logic [7:0]          col_color;
    logic [6:0]          col_tex_x;

    modport slave (
        input  frame_start, frame_turn, frame_pos_x, frame_pos_y,
        output frame_busy, frame_done, timeout_err,
        output ray_x, ray_turn, ray_map_pos_x, ray_map_pos_y, ray_start,
        input  ray_busy, ray_line_height, ray_line_color, ray_line_tex_x,
        output col_we, col_addr, col_height, col_color, col_tex_x
    );

    modport master (
        output frame_start, frame_turn, frame_pos_x, frame_pos_y,
        input  frame_busy, frame_done, timeout_err,
        input  ray_x, ray_turn, ray_map_pos_x, ray_map_pos_y, ray_start,
        output ray_busy, ray_line_height, ray_line_color, ray_line_tex_x,
        input  col_we, col_addr, col_height, col_color, col_tex_x
    );
endinterface

// File: rtl/ray_column_sched.sv
// Frame sequencer for one ray caster: snapshots the view, casts every screen column
// in order and writes the clamped result into the column buffer.
module ray_column_sched #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int HEIGHT_W = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic               clk,
    input  logic               rst,
    ray_column_sched_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_WRITE, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [8:0]          x_q, x_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic [6:0]          turn_q, turn_d;
    logic [15:0]         pos_x_q, pos_x_d;
    logic [15:0]         pos_y_q, pos_y_d;
    logic [HEIGHT_W-1:0] height_q, height_d;
    logic [7:0]          color_q, color_d;
    logic [6:0]          tex_q, tex_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                terr_q, terr_d;
    logic                start_q, start_d;
    logic                we_q, we_d;
    logic [HEIGHT_W-1:0] clamped;

    // Full 24-bit compare: a large height must not alias into range via its low bits.
    assign clamped = (bus.ray_line_height > 24'(SCREEN_H)) ? HEIGHT_W'(SCREEN_H)
                                                           : bus.ray_line_height[HEIGHT_W-1:0];

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        wait_d   = wait_q;
        turn_d   = turn_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        height_d = height_q;
        color_d  = color_q;
        tex_d    = tex_q;
        busy_d   = busy_q;
        terr_d   = terr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    turn_d  = bus.frame_turn;
                    pos_x_d = bus.frame_pos_x;
                    pos_y_d = bus.frame_pos_y;
                    x_d     = '0;
                    terr_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_ARM;
            S_ARM: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.ray_busy) begin
                    height_d = clamped;
                    color_d  = bus.ray_line_color;
                    tex_d    = bus.ray_line_tex_x;
                    state_d  = S_WRITE;
                end else if (wait_q == CNT_W'(TIMEOUT)) begin
                    height_d = '0;
                    color_d  = '0;
                    tex_d    = '0;
                    terr_d   = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (x_q == 9'(SCREEN_W - 1)) begin
                    state_d = S_DONE;
                end else begin
                    x_d     = x_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with that state.
        start_d = (state_d == S_ISSUE);
        we_d    = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            wait_q   <= '0;
            turn_q   <= '0;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            height_q <= '0;
            color_q  <= '0;
            tex_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
            start_q  <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            wait_q   <= wait_d;
            turn_q   <= turn_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            height_q <= height_d;
            color_q  <= color_d;
            tex_q    <= tex_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
            start_q  <= start_d;
            we_q     <= we_d;
        end
    end

    assign bus.frame_busy    = busy_q;
    assign bus.frame_done    = done_q;
    assign bus.timeout_err   = terr_q;
    assign bus.ray_x         = x_q;
    assign bus.ray_turn      = turn_q;
    assign bus.ray_map_pos_x = pos_x_q;
    assign bus.ray_map_pos_y = pos_y_q;
    assign bus.ray_start     = start_q;
    assign bus.col_we        = we_q;
    assign bus.col_addr      = x_q;
    assign bus.col_height    = height_q;
    assign bus.col_color     = color_q;
    assign bus.col_tex_x     = tex_q;
endmodule

// File: tb/tb_ray_column_sched.sv
// Self-checking bench: a behavioural caster plus a write scoreboard filled with the
// full expected column sequence whenever a frame is requested.
module tb_ray_column_sched;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int HEIGHT_W = 8;
    localparam int TIMEOUT  = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ray_column_sched_if #(.HEIGHT_W(HEIGHT_W)) bus ();

    ray_column_sched #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .HEIGHT_W(HEIGHT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_writes = 0;
    int n_done = 0;
    int c_issue = 0;
    int c_done = 0;
    int c_stuck_start = 0;
    logic busy_prev = 1'b0;

    int lat = 0;
    int stuck_x = -1;
    int hmode = 0;
    int cnt = 0;
    logic stuck = 1'b0;

    bit snap_en = 1'b0;
    logic [6:0]  snap_turn = '0;
    logic [15:0] snap_px = '0;
    logic [15:0] snap_py = '0;

    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] height_of(input logic [8:0] x, input int mode);
        if (mode == 0) return {15'd0, x};
        case (x % 9'd5)
            9'd0:    return 24'h001000;
            9'd1:    return 24'd240;
            9'd2:    return 24'd241;
            9'd3:    return 24'd7;
            default: return 24'h0100F0;
        endcase
    endfunction

    function automatic logic [7:0] color_of(input logic [8:0] x);
        return x[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [6:0] tex_of(input logic [8:0] x);
        return x[8:2];
    endfunction

    function automatic logic [7:0] exp_height(input logic [23:0] h);
        return (h > 24'd240) ? 8'd240 : h[7:0];
    endfunction

    function automatic logic [127:0] outs();
        return 128'({bus.frame_busy, bus.frame_done, bus.timeout_err, bus.ray_x, bus.ray_turn,
                     bus.ray_map_pos_x, bus.ray_map_pos_y, bus.ray_start, bus.col_we,
                     bus.col_addr, bus.col_height, bus.col_color, bus.col_tex_x});
    endfunction

    // Behavioural caster: busy for lat+1 cycles after start, or forever on the stuck column.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            bus.ray_busy        <= 1'b0;
            bus.ray_line_height <= '0;
            bus.ray_line_color  <= '0;
            bus.ray_line_tex_x  <= '0;
            cnt   <= 0;
            stuck <= 1'b0;
        end else if (bus.ray_start) begin
            bus.ray_busy        <= 1'b1;
            bus.ray_line_height <= height_of(bus.ray_x, hmode);
            bus.ray_line_color  <= color_of(bus.ray_x);
            bus.ray_line_tex_x  <= tex_of(bus.ray_x);
            cnt   <= lat;
            stuck <= (int'(bus.ray_x) == stuck_x);
        end else if (bus.ray_busy && !stuck) begin
            if (cnt == 0) bus.ray_busy <= 1'b0;
            else          cnt <= cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_busy && !busy_prev) c_issue = cyc;
            busy_prev = bus.frame_busy;
            if (bus.ray_start && int'(bus.ray_x) == stuck_x) c_stuck_start = cyc;
            if (bus.col_we) begin
                n_writes++;
                check("sb_nonempty", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0)
                    check("col_write", 128'({bus.col_addr, bus.col_height, bus.col_color, bus.col_tex_x}),
                          128'(sb.pop_front()));
                if (snap_en)
                    check("snapshot", 128'({bus.ray_turn, bus.ray_map_pos_x, bus.ray_map_pos_y}),
                          128'({snap_turn, snap_px, snap_py}));
                if (int'(bus.col_addr) == stuck_x) begin
                    check("timeout_len", 128'(cyc - c_stuck_start), 128'(TIMEOUT + 3));
                    check("timeout_err_set", 128'(bus.timeout_err), 128'd1);
                end
            end
            if (bus.frame_done) begin
                n_done++;
                c_done = cyc;
            end
        end else begin
            busy_prev = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input int mode, input int stuck_col);
        for (int x = 0; x < SCREEN_W; x++) begin
            logic [8:0] xa;
            logic [23:0] h;
            xa = 9'(x);
            h  = height_of(xa, mode);
            if (x == stuck_col) sb.push_back({xa, 23'd0});
            else                sb.push_back({xa, exp_height(h), color_of(xa), tex_of(xa)});
        end
    endtask

    task automatic start_frame(input logic [6:0] t, input logic [15:0] px, input logic [15:0] py);
        bus.frame_turn  = t;
        bus.frame_pos_x = px;
        bus.frame_pos_y = py;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int i;
        d0 = n_done;
        i = 0;
        while (n_done == d0 && i < budget) begin
            tick();
            i++;
        end
        check({tag, "_done_in_budget"}, 128'(n_done != d0), 128'd1);
    endtask

    task automatic run_frame(input string tag, input int mode, input int lat_v, input int stuck_col,
                             input logic [6:0] t, input logic [15:0] px);
        int w0;
        hmode   = mode;
        lat     = lat_v;
        stuck_x = stuck_col;
        push_frame(mode, stuck_col);
        w0 = n_writes;
        start_frame(t, px, 16'h0200);
        wait_done(20000, tag);
        check({tag, "_writes"}, 128'(n_writes - w0), 128'(SCREEN_W));
        check({tag, "_sb_drained"}, 128'(sb.size()), 128'd0);
        tick();
        check({tag, "_done_pulse"}, 128'({bus.frame_done, bus.frame_busy}), 128'd0);
    endtask

    initial begin
        int w0;
        int c_done1;
        bus.frame_start = 1'b0;
        bus.frame_turn  = '0;
        bus.frame_pos_x = '0;
        bus.frame_pos_y = '0;

        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs", outs(), 128'd0);
        rst = 1'b0;
        tick();

        // Full frame, 20-cycle caster, height = x.
        run_frame("frame_lat20", 0, 20, -1, 7'd3, 16'h0100);
        check("frame_cycles", 128'(c_done - (c_issue - 1) + 1), 128'(SCREEN_W * 24 + 2));
        check("frame_no_timeout", 128'(bus.timeout_err), 128'd0);

        // Clamp patterns with the minimum 4-cycle column.
        run_frame("clamp", 1, 0, -1, 7'd9, 16'h0300);
        check("clamp_cycles", 128'(c_done - c_issue), 128'(SCREEN_W * 4));

        // View inputs change mid-frame; latched view must hold.
        hmode = 0; lat = 2; stuck_x = -1;
        push_frame(0, -1);
        snap_turn = 7'd16; snap_px = 16'h130c; snap_py = 16'h0a80; snap_en = 1'b1;
        w0 = n_writes;
        start_frame(7'd16, 16'h130c, 16'h0a80);
        repeat (50) tick();
        bus.frame_turn  = 7'd40;
        bus.frame_pos_x = 16'hbeef;
        bus.frame_pos_y = 16'h1234;
        wait_done(20000, "snap");
        check("snap_at_done", 128'({bus.ray_turn, bus.ray_map_pos_x}), 128'({7'd16, 16'h130c}));
        check("snap_writes", 128'(n_writes - w0), 128'(SCREEN_W));
        snap_en = 1'b0;
        tick();

        // frame_start held high: back-to-back frames with one IDLE cycle between.
        hmode = 0; lat = 0;
        push_frame(0, -1);
        push_frame(0, -1);
        w0 = n_writes;
        bus.frame_start = 1'b1;
        wait_done(20000, "b2b_first");
        c_done1 = c_done;
        wait_done(20000, "b2b_second");
        bus.frame_start = 1'b0;
        check("b2b_gap", 128'(c_issue - c_done1), 128'd2);
        check("b2b_writes", 128'(n_writes - w0), 128'(2 * SCREEN_W));
        tick();
        tick();
        check("b2b_no_third", 128'(bus.frame_busy), 128'd0);

        // Caster stuck on column 5.
        run_frame("timeout", 0, 0, 5, 7'd1, 16'h0400);
        check("timeout_sticky", 128'(bus.timeout_err), 128'd1);
        stuck_x = -1;
        push_frame(0, -1);
        start_frame(7'd2, 16'h0500, 16'h0600);
        check("accept_clears_err", 128'({bus.timeout_err, bus.frame_busy}), 128'b01);
        wait_done(20000, "after_timeout");
        check("after_timeout_sb", 128'(sb.size()), 128'd0);
        tick();

        // Reset while waiting on column 100.
        hmode = 0; lat = 20; stuck_x = -1;
        push_frame(0, -1);
        w0 = n_writes;
        start_frame(7'd5, 16'h0700, 16'h0800);
        for (int i = 0; i < 5000 && !(bus.ray_start && bus.ray_x == 9'd100); i++) tick();
        check("reached_x100", 128'({bus.ray_start, bus.ray_x}), 128'({1'b1, 9'd100}));
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midframe_reset_outputs", outs(), 128'd0);
        check("midframe_writes", 128'(n_writes - w0), 128'd100);
        rst = 1'b0;
        sb.delete();
        tick();
        run_frame("post_reset", 1, 0, -1, 7'd6, 16'h0900);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
